rv_ri_core_param: RTL and testbench
===================================

// Module: rv_ri_core_param
// PURPOSE
//  Parametrised single-cycle RV32I/RV64I R/I-type integer core: PC, register file,
//  ALU and writeback. Adds an instruction-fetch handshake with stall, illegal-
//  instruction halt and a retired-instruction counter. Instruction memory is
//  external. alu_out/wr_back_data are exposed for bench observation.
// PARAMETERS
//  DATA_WIDTH  32   register/ALU/PC width; only 32 or 64 are legal
//  NUM_REGS    32   architectural registers; 16 (RV32E) or 32; x0 is hard-wired 0
//  RESET_PC    0    PC value loaded on reset
//  CNT_WIDTH   32   width of the retire counter
// PORTS
//  clk1          in   1           clock; all state updates on posedge
//  reset1        in   1           synchronous reset, ACTIVE-LOW
//  imem_valid    in   1           imem_rdata is valid this cycle
//  imem_rdata    in   32          instruction at PC (combinational read)
//  PC            out  DATA_WIDTH  current program counter, also the fetch address
//  alu_out       out  DATA_WIDTH  combinational ALU result for the current instruction
//  wr_back_data  out  DATA_WIDTH  data written to rd (equals alu_out)
//  wr_en         out  1           1 when rd is written at the next posedge
//  halted        out  1           1 once an illegal instruction has been seen
//  trap_pc       out  DATA_WIDTH  PC of the illegal instruction; 0 until halt
//  retire_cnt    out  CNT_WIDTH   count of retired instructions
// BEHAVIOUR
//  - Reset: at a posedge with reset1==0: PC=RESET_PC, all regs=0, retire_cnt=0,
//    halted=0, trap_pc=0, state=RUN. Reset overrides every other event, including
//    mid-stall and HALT.
//  - FSM states RUN and HALT. RUN->HALT on an illegal instruction with imem_valid=1.
//    HALT->RUN only through reset.
//  - RUN, imem_valid=1, legal instruction: one-cycle execute. At the next posedge,
//    rd is written if rd!=0, PC+=4 (wraps modulo 2^DATA_WIDTH) and retire_cnt+=1.
//    retire_cnt saturates at all-ones.
//  - RUN, imem_valid=0: stall. PC, regs and retire_cnt hold; wr_en=0.
//  - HALT: PC holds at trap_pc; wr_en=0; no further state changes.
//  - wr_en = RUN & imem_valid & legal & (rd!=0). alu_out is don't-care when wr_en=0.
//  - Legal opcodes are 0110011 (R) and 0010011 (I); everything else is illegal.
//  - R-type: funct7=0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000
//    is legal only with SUB (f3=000) or SRA (f3=101). Any other combination is illegal.
//  - I-type: ADDI/SLTI/SLTIU/XORI/ORI/ANDI. The immediate is sign-extended from
//    bit 31 to DATA_WIDTH; SLTIU compares the sign-extended immediate unsigned.
//  - Shifts: amount = low log2(DATA_WIDTH) bits of rs2 or immediate.
//    SLLI/SRLI/SRAI use the upper immediate bits as funct
//    (6 bits when DATA_WIDTH=64, 7 bits when 32); a nonzero value other than the
//    SRAI encoding is illegal. SRA/SRAI shift in the sign bit.
//  - SLT/SLTU results are zero-extended to DATA_WIDTH. No overflow detection.
//  - Register index >= NUM_REGS in rs1, rs2 or rd is illegal.
//  - Register reads are asynchronous and see all writes committed at earlier edges.
//  - Writes to x0 are discarded.
// TESTING
//  1 reset1=0 for 2 clk, then 1 -> PC=0, retire_cnt=0, halted=0, x1..x31=0.
//  2 ADDI x1,x0,-5; ADDI x2,x0,3; SUB x3,x1,x2; SLTU x4,x2,x1 -> x3=0xFFFFFFF8,
//    x4=1, retire_cnt=4, PC=0x10.
//  3 x1=0x80000000: SRAI x5,x1,4 -> 0xF8000000; SRLI x6,x1,4 -> 0x08000000;
//    ADDI x0,x0,7 -> x0 stays 0, wr_en=0.
//  4 imem_valid low for 3 cycles mid-program -> PC, regs and retire_cnt frozen;
//    execution resumes correctly after valid returns.
//  5 instruction 0x00000073 at PC=0x8 -> halted=1, trap_pc=8, PC holds at 8,
//    no writes; reset1=0 clears halted and restarts from PC=0.
//  6 DATA_WIDTH=64: SLLI x1,x1,40 with x1=1 -> 0x0000010000000000;
//    CNT_WIDTH=2: 5 retires -> retire_cnt=3 (saturated).

Source files
------------

// File: rtl/rv_ri_core_param.sv
// Single-cycle RV32I/RV64I R/I-type integer core with fetch stall,
// illegal-instruction halt and a saturating retire counter.
module rv_ri_core_param #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 32
) (
    input  logic                  clk1,
    input  logic                  reset1,
    input  logic                  imem_valid,
    input  logic [31:0]           imem_rdata,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0] wr_back_data,
    output logic                  wr_en,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] trap_pc,
    output logic [CNT_WIDTH-1:0]  retire_cnt
);
    localparam int SHW = (DATA_WIDTH == 64) ? 6 : 5;
    localparam int FW  = 12 - SHW;
    localparam int RW  = $clog2(NUM_REGS);
    localparam logic [FW-1:0] SRAI_F = FW'(1) << (FW - 2);

    typedef enum logic {RUN, HALT} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] trap_q, trap_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];

    logic [6:0]            opcode, f7;
    logic [4:0]            rd, rs1, rs2;
    logic [2:0]            f3;
    logic [FW-1:0]         fhi;
    logic                  is_r, is_i, regs_ok, legal;
    logic [DATA_WIDTH-1:0] imm, op_a, op_b, alu, sra_res;
    logic [SHW-1:0]        shamt;

    assign opcode = imem_rdata[6:0];
    assign rd     = imem_rdata[11:7];
    assign f3     = imem_rdata[14:12];
    assign rs1    = imem_rdata[19:15];
    assign rs2    = imem_rdata[24:20];
    assign f7     = imem_rdata[31:25];
    assign fhi    = imem_rdata[31:20+SHW];
    assign is_r   = (opcode == 7'b0110011);
    assign is_i   = (opcode == 7'b0010011);

    // rs2 is only a register index for R-type; for I-type it is immediate bits
    assign regs_ok = (int'(rd) < NUM_REGS) && (int'(rs1) < NUM_REGS)
                   && (!is_r || int'(rs2) < NUM_REGS);

    always_comb begin
        legal = 1'b0;
        if (is_r) begin
            legal = (f7 == 7'h00)
                  || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end else if (is_i) begin
            case (f3)
                3'd1:    legal = (fhi == '0);
                3'd5:    legal = (fhi == '0) || (fhi == SRAI_F);
                default: legal = 1'b1;
            endcase
        end
        legal = legal && regs_ok;
    end

    assign imm     = {{(DATA_WIDTH-12){imem_rdata[31]}}, imem_rdata[31:20]};
    assign op_a    = rf_q[rs1[RW-1:0]];
    assign op_b    = is_r ? rf_q[rs2[RW-1:0]] : imm;
    assign shamt   = op_b[SHW-1:0];
    assign sra_res = $signed(op_a) >>> shamt;

    // bit 30 distinguishes SUB/SRA/SRAI in both widths
    always_comb begin
        alu = '0;
        case (f3)
            3'd0: alu = (is_r && imem_rdata[30]) ? op_a - op_b : op_a + op_b;
            3'd1: alu = op_a << shamt;
            3'd2: alu = {{(DATA_WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            3'd3: alu = {{(DATA_WIDTH-1){1'b0}}, op_a < op_b};
            3'd4: alu = op_a ^ op_b;
            3'd5: alu = imem_rdata[30] ? sra_res : op_a >> shamt;
            3'd6: alu = op_a | op_b;
            3'd7: alu = op_a & op_b;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (!reset1) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (imem_valid && !legal) state_d = HALT;
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wr_en  = 1'b0;
        halted = 1'b0;
        case (state_q)
            RUN:     wr_en = imem_valid && legal && (rd != 5'd0);
            HALT:    halted = 1'b1;
            default: wr_en = 1'b0;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        trap_d = trap_q;
        rf_d   = rf_q;
        if (state_q == RUN && imem_valid) begin
            if (legal) begin
                pc_d = pc_q + DATA_WIDTH'(4);
                if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
            end else begin
                trap_d = pc_q;
            end
        end
        if (wr_en) rf_d[rd[RW-1:0]] = alu;
    end

    always_ff @(posedge clk1) begin
        if (!reset1) begin
            pc_q   <= RESET_PC;
            cnt_q  <= '0;
            trap_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            trap_q <= trap_d;
            rf_q   <= rf_d;
        end
    end

    assign PC           = pc_q;
    assign alu_out      = alu;
    assign wr_back_data = alu;
    assign trap_pc      = trap_q;
    assign retire_cnt   = cnt_q;
endmodule

// File: tb/tb_rv_ri_core_param.sv
// Bench for rv_ri_core_param: a 32-bit core checked against an ISA
// reference model, plus a 64-bit / 16-reg / 2-bit-counter core.
module tb_rv_ri_core_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        valid_a = 1'b0;
    logic [31:0] rdata_a = '0;
    logic [31:0] pc_a, alu_a, wb_a, trap_a, cnt_a;
    logic        we_a, halted_a;

    logic        valid_b = 1'b0;
    logic [31:0] rdata_b = '0;
    logic [63:0] pc_b, alu_b, wb_b, trap_b;
    logic [1:0]  cnt_b;
    logic        we_b, halted_b;

    rv_ri_core_param u_dut_a (
        .clk1(clk), .reset1(rst_n), .imem_valid(valid_a), .imem_rdata(rdata_a),
        .PC(pc_a), .alu_out(alu_a), .wr_back_data(wb_a), .wr_en(we_a),
        .halted(halted_a), .trap_pc(trap_a), .retire_cnt(cnt_a)
    );

    rv_ri_core_param #(
        .DATA_WIDTH(64), .NUM_REGS(16), .RESET_PC(64'h100), .CNT_WIDTH(2)
    ) u_dut_b (
        .clk1(clk), .reset1(rst_n), .imem_valid(valid_b), .imem_rdata(rdata_b),
        .PC(pc_b), .alu_out(alu_b), .wr_back_data(wb_b), .wr_en(we_b),
        .halted(halted_b), .trap_pc(trap_b), .retire_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];

    logic [31:0] mregs [32];
    logic [31:0] m_pc, m_trap, m_cnt;
    bit          m_halt;

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] im, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {im, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic void ref_exec(input logic [31:0] ins, output bit ok,
                                     output logic [31:0] res);
        logic [31:0] a, b, im;
        a   = mregs[ins[19:15]];
        b   = mregs[ins[24:20]];
        im  = {{20{ins[31]}}, ins[31:20]};
        ok  = 1;
        res = '0;
        if (ins[6:0] == 7'h33) begin
            case ({ins[31:25], ins[14:12]})
                {7'h00, 3'd0}: res = a + b;
                {7'h20, 3'd0}: res = a - b;
                {7'h00, 3'd1}: res = a << b[4:0];
                {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                {7'h00, 3'd3}: res = (a < b) ? 32'd1 : 32'd0;
                {7'h00, 3'd4}: res = a ^ b;
                {7'h00, 3'd5}: res = a >> b[4:0];
                {7'h20, 3'd5}: res = $signed(a) >>> b[4:0];
                {7'h00, 3'd6}: res = a | b;
                {7'h00, 3'd7}: res = a & b;
                default:       ok = 0;
            endcase
        end else if (ins[6:0] == 7'h13) begin
            case (ins[14:12])
                3'd0: res = a + im;
                3'd2: res = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
                3'd3: res = (a < im) ? 32'd1 : 32'd0;
                3'd4: res = a ^ im;
                3'd6: res = a | im;
                3'd7: res = a & im;
                3'd1: if (ins[31:25] == 7'h00) res = a << ins[24:20]; else ok = 0;
                default: begin
                    if (ins[31:25] == 7'h00)      res = a >> ins[24:20];
                    else if (ins[31:25] == 7'h20) res = $signed(a) >>> ins[24:20];
                    else                          ok = 0;
                end
            endcase
        end else begin
            ok = 0;
        end
    endfunction

    task automatic rst();
        @(negedge clk);
        rst_n = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        m_pc = '0; m_trap = '0; m_cnt = '0; m_halt = 0;
        chk("rst_pc", pc_a, m_pc);
        chk("rst_cnt", cnt_a, m_cnt);
        chk("rst_halted", halted_a, m_halt);
        chk("rst_trap", trap_a, m_trap);
    endtask

    task automatic step_a(input logic v, input logic [31:0] ins);
        sb_t e;
        bit ok;
        logic [31:0] r;
        @(negedge clk);
        valid_a = v;
        rdata_a = ins;
        ref_exec(ins, ok, r);
        e.we   = v && ok && !m_halt && (ins[11:7] != 5'd0);
        e.data = r;
        sb_q.push_back(e);
        #1;
        e = sb_q.pop_front();
        chk("wr_en", we_a, e.we);
        if (e.we) chk("wb_data", wb_a, e.data);
        @(posedge clk);
        #1;
        if (v && !m_halt) begin
            if (!ok) begin
                m_halt = 1;
                m_trap = m_pc;
            end else begin
                if (ins[11:7] != 5'd0) mregs[ins[11:7]] = r;
                m_pc = m_pc + 32'd4;
                if (m_cnt != '1) m_cnt = m_cnt + 32'd1;
            end
        end
        chk("pc", pc_a, m_pc);
        chk("retire_cnt", cnt_a, m_cnt);
        chk("halted", halted_a, m_halt);
        chk("trap_pc", trap_a, m_trap);
    endtask

    task automatic step_b(input string tag, input logic [31:0] ins,
                          input logic we, input logic [63:0] wb);
        @(negedge clk);
        valid_b = 1'b1;
        rdata_b = ins;
        #1;
        chk({tag, "_we"}, we_b, we);
        if (we) chk(tag, wb_b, wb);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ill_tab [7];

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        ill_tab[0] = 32'h0000_0073;
        ill_tab[1] = r_ins(7'h20, 5'd2, 5'd1, 3'd1, 5'd3);
        ill_tab[2] = i_ins(12'h404, 5'd1, 3'd1, 5'd3);
        ill_tab[3] = i_ins(12'h204, 5'd1, 3'd5, 5'd3);
        ill_tab[4] = r_ins(7'h01, 5'd2, 5'd1, 3'd0, 5'd3);
        ill_tab[5] = 32'h0000_10B7;
        ill_tab[6] = i_ins(12'h020, 5'd1, 3'd1, 5'd3);

        rst();
        step_a(1, r_ins(7'h00, 5'd31, 5'd30, 3'd0, 5'd9));
        step_a(1, i_ins(12'hFFB, 5'd0, 3'd0, 5'd1));
        step_a(1, i_ins(12'h003, 5'd0, 3'd0, 5'd2));
        step_a(1, r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd3));
        step_a(1, r_ins(7'h00, 5'd1, 5'd2, 3'd3, 5'd4));
        chk("prog_pc", pc_a, 32'h14);
        chk("prog_cnt", cnt_a, 32'd5);

        step_a(1, i_ins(12'h001, 5'd0, 3'd0, 5'd1));
        step_a(1, i_ins(12'h01F, 5'd1, 3'd1, 5'd1));
        step_a(1, i_ins(12'h404, 5'd1, 3'd5, 5'd5));
        step_a(1, i_ins(12'h004, 5'd1, 3'd5, 5'd6));
        step_a(1, i_ins(12'h007, 5'd0, 3'd0, 5'd0));

        repeat (3) step_a(0, 32'h0000_0073);

        step_a(1, r_ins(7'h00, 5'd6, 5'd5, 3'd4, 5'd7));
        step_a(1, r_ins(7'h00, 5'd2, 5'd1, 3'd2, 5'd8));
        step_a(1, i_ins(12'hFFF, 5'd2, 3'd3, 5'd10));
        step_a(1, i_ins(12'hFFF, 5'd2, 3'd2, 5'd11));
        step_a(1, i_ins(12'h0F0, 5'd5, 3'd7, 5'd12));
        step_a(1, i_ins(12'h5A5, 5'd2, 3'd6, 5'd13));
        step_a(1, i_ins(12'hFFF, 5'd6, 3'd4, 5'd14));
        step_a(1, r_ins(7'h00, 5'd2, 5'd6, 3'd1, 5'd15));
        step_a(1, r_ins(7'h00, 5'd2, 5'd5, 3'd5, 5'd16));
        step_a(1, r_ins(7'h20, 5'd2, 5'd5, 3'd5, 5'd17));
        step_a(1, r_ins(7'h00, 5'd5, 5'd6, 3'd6, 5'd18));
        step_a(1, r_ins(7'h00, 5'd5, 5'd6, 3'd7, 5'd19));
        step_a(1, r_ins(7'h00, 5'd1, 5'd5, 3'd3, 5'd20));

        rst();
        step_a(1, i_ins(12'h00A, 5'd0, 3'd0, 5'd1));
        step_a(1, i_ins(12'h00B, 5'd1, 3'd0, 5'd2));
        step_a(1, 32'h0000_0073);
        chk("halt_flag", halted_a, 1'b1);
        chk("halt_trap", trap_a, 32'h8);
        chk("halt_pc", pc_a, 32'h8);
        step_a(1, i_ins(12'h001, 5'd0, 3'd0, 5'd1));
        step_a(0, i_ins(12'h001, 5'd0, 3'd0, 5'd1));
        rst();

        foreach (ill_tab[k]) begin
            rst();
            step_a(1, ill_tab[k]);
            chk("ill_halt", halted_a, 1'b1);
        end

        rst();
        chk("b_rst_pc", pc_b, 64'h100);
        chk("b_rst_cnt", cnt_b, 2'd0);
        step_b("b_addi", i_ins(12'h001, 5'd0, 3'd0, 5'd1), 1'b1, 64'h1);
        step_b("b_slli40", i_ins(12'h028, 5'd1, 3'd1, 5'd1), 1'b1, 64'h0000_0100_0000_0000);
        step_b("b_srai", i_ins(12'h408, 5'd1, 3'd5, 5'd2), 1'b1, 64'h0000_0001_0000_0000);
        chk("b_cnt3", cnt_b, 2'd3);
        chk("b_pc3", pc_b, 64'h10C);
        step_b("b_m1", i_ins(12'hFFF, 5'd0, 3'd0, 5'd3), 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        step_b("b_srli60", i_ins(12'h03C, 5'd3, 3'd5, 5'd4), 1'b1, 64'hF);
        chk("b_cnt_sat", cnt_b, 2'd3);
        chk("b_pc5", pc_b, 64'h114);
        step_b("b_rd16", i_ins(12'h001, 5'd0, 3'd0, 5'd16), 1'b0, 64'h0);
        chk("b_halted", halted_b, 1'b1);
        chk("b_trap", trap_b, 64'h114);
        chk("b_halt_pc", pc_b, 64'h114);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
